conv_arbiter: RTL and testbench
===============================

Name: conv_arbiter

Overview:
- Shares one fixed-to-float `converter` instance between NUM_REQ requesters.
- Arbitrates round-robin, then latches the winner's operands and drives the converter's `fixed`/`exp_in`/`load_new` inputs.
- Waits out the converter's iterative normalisation latency, captures `float` and returns it with the requester ID over a valid/ready response channel.
- Sits between the compute clients and the converter; the converter itself is unchanged.

Parameters:
- NUM_REQ, 4: number of requesters (>=2).
- ID_W, $clog2(NUM_REQ): width of the requester ID.
- CONV_CYCLES, 40: clock cycles after the `load_new` pulse before `conv_float` is guaranteed valid (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request; held, with operands, until that requester's grant.
- req_fixed  in  NUM_REQ*32  operand i at bits [32i+31:32i]; signed fixed-point.
- req_exp  in  NUM_REQ*8  exponent i at bits [8i+7:8i]; two's complement.
- grant  out  NUM_REQ  one-hot, combinational, IDLE only; operands captured at that edge.
- conv_fixed  out  32  to `converter.fixed`.
- conv_exp  out  8  to `converter.exp_in`.
- conv_load  out  1  to `converter.load_new`; one-cycle pulse.
- conv_float  in  32  from `converter.float`.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  index of the requester owning the result.
- rsp_float  out  32  IEEE-754 single result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, rr_ptr=0.
  - grant, conv_load, rsp_valid and busy are 0.
  - conv_fixed, conv_exp, rsp_id and rsp_float are 0.
  - An in-flight conversion is abandoned; its result is never presented.
- FSM states: IDLE, LOAD, WAIT, RESP.
- IDLE:
  - If req is nonzero, select the first set bit scanning rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_REQ.
  - Drive grant[sel]=1 in that cycle.
  - At the edge: latch req_fixed[sel] into conv_fixed, req_exp[sel] into conv_exp, sel into rsp_id; set rr_ptr=(sel+1) mod NUM_REQ; go to LOAD.
  - If req==0, stay in IDLE; grant=0.
- LOAD: conv_load=1 for exactly this cycle; load the wait counter with CONV_CYCLES-1; go to WAIT.
- WAIT:
  - conv_load=0; conv_fixed and conv_exp are held stable.
  - Counter decrements each cycle. At count 0, capture conv_float into rsp_float and go to RESP.
  - WAIT therefore lasts exactly CONV_CYCLES cycles.
- RESP:
  - rsp_valid=1; rsp_id and rsp_float are held stable.
  - On rsp_valid and rsp_ready: go to IDLE.
  - rsp_valid drops the following cycle; no same-cycle re-grant.
- Timing, with grant at cycle T:
  - conv_load at T+1.
  - rsp_valid first high at T+2+CONV_CYCLES when no backpressure.
  - Minimum throughput: one result per CONV_CYCLES+3 cycles.
- req is sampled only in IDLE. Changes to req or operands outside IDLE are ignored.
- grant is never asserted for a requester whose req is low.
- Only one conversion is in flight at a time; there is no queueing.

Optional Feature:
- Macro: CONV_ZERO_BYPASS_EN.
- Defined:
  - If the selected req_fixed equals 32'h0, the converter is skipped: IDLE goes directly to RESP.
  - rsp_float=32'h00000000; conv_load is not pulsed; rsp_valid is high at T+1.
  - Purpose: the converter's normalisation loop has no leading one to find for a zero input.
- Not defined: zero operands follow the normal LOAD/WAIT path, and rsp_float is whatever the converter produces.

Test Plan:
1. Single request, after reset, req=4'b0001, fixed=32'h1, exp=8'h00:
   - grant=0001 for 1 cycle; conv_load pulses at T+1.
   - rsp_valid at T+2+CONV_CYCLES with rsp_id=0 and rsp_float=32'h3F800000.
2. All-at-once, req=4'b1111, operands (1,8'h01), (32'hD,8'hFF), (32'hFFFFFFFF,8'h00), (1,8'h00), rsp_ready tied high:
   - Grants in order 0,1,2,3.
   - Responses 40000000/id0, 40D00000/id1, BF800000/id2, 3F800000/id3.
3. Fairness, req0 and req2 held high for 6 transactions -> grant sequence 0,2,0,2,0,2.
4. Backpressure, rsp_ready low for 10 cycles in RESP:
   - rsp_valid stays high; rsp_float and rsp_id are stable.
   - grant=0 and conv_load=0 throughout; exactly one transfer when rsp_ready rises.
5. Reset mid-WAIT, rst_n low for 2 cycles:
   - Outputs are zero immediately (asynchronous); the abandoned result never appears.
   - With req=4'b1010 afterwards, the first grant goes to requester 1 (rr_ptr=0).
6. CONV_ZERO_BYPASS_EN defined, req0 with fixed=0:
   - No conv_load pulse; rsp_valid at T+1 with 32'h00000000.
   - Without the macro, conv_load pulses and the result arrives at T+2+CONV_CYCLES.

Source files
------------

// File: rtl/conv_arbiter.sv
// Round-robin front end sharing one fixed-to-float converter between NUM_REQ clients.
// Optional: define CONV_ZERO_BYPASS_EN to answer zero operands directly without the converter.
module conv_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = $clog2(NUM_REQ),
    parameter int CONV_CYCLES = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*32-1:0] req_fixed,
    input  logic [NUM_REQ*8-1:0] req_exp,
    output logic [NUM_REQ-1:0]   grant,
    output logic [31:0]          conv_fixed,
    output logic [7:0]           conv_exp,
    output logic                 conv_load,
    input  logic [31:0]          conv_float,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_float,
    output logic                 busy
);

    localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       conv_fixed_q, conv_fixed_d;
    logic [7:0]        conv_exp_q, conv_exp_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [31:0]       rsp_float_q, rsp_float_d;
    logic              conv_load_q, conv_load_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;

    logic              found;
    logic [ID_W-1:0]   sel;
    logic [31:0]       sel_fixed;
    logic [7:0]        sel_exp;
    logic [NUM_REQ-1:0] grant_w;
    int unsigned       idx;

    // Rotating-priority scan starting at rr_ptr; first asserted request wins.
    always_comb begin
        found     = 1'b0;
        sel       = '0;
        sel_fixed = '0;
        sel_exp   = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found     = 1'b1;
                sel       = ID_W'(idx);
                sel_fixed = req_fixed[32*idx +: 32];
                sel_exp   = req_exp[8*idx +: 8];
            end
        end
    end

    always_comb begin
        grant_w = '0;
        if (state_q == IDLE && found && rst_n) begin
            grant_w[sel] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        conv_fixed_d = conv_fixed_q;
        conv_exp_d   = conv_exp_q;
        rsp_id_d     = rsp_id_q;
        rsp_float_d  = rsp_float_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    conv_fixed_d = sel_fixed;
                    conv_exp_d   = sel_exp;
                    rsp_id_d     = sel;
                    rr_ptr_d     = ID_W'((32'(sel) + 32'd1) % NUM_REQ);
                    state_d      = LOAD;
`ifdef CONV_ZERO_BYPASS_EN
                    if (sel_fixed == '0) begin
                        rsp_float_d = '0;
                        state_d     = RESP;
                    end
`endif
                end
            end
            LOAD: begin
                cnt_d   = CNT_W'(CONV_CYCLES - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_float_d = conv_float;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Output flops are decoded from the next state so they line up with the state register.
        conv_load_d = (state_d == LOAD);
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            conv_fixed_q <= '0;
            conv_exp_q   <= '0;
            rsp_id_q     <= '0;
            rsp_float_q  <= '0;
            conv_load_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            conv_fixed_q <= conv_fixed_d;
            conv_exp_q   <= conv_exp_d;
            rsp_id_q     <= rsp_id_d;
            rsp_float_q  <= rsp_float_d;
            conv_load_q  <= conv_load_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign grant      = grant_w;
    assign conv_fixed = conv_fixed_q;
    assign conv_exp   = conv_exp_q;
    assign conv_load  = conv_load_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_float  = rsp_float_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_conv_arbiter.sv
// Directed bench for conv_arbiter with a behavioural converter of fixed CONV_CYCLES latency.
module tb_conv_arbiter;

    localparam int C = 40;
    localparam logic [31:0] GARB = 32'h7FC0DEAD;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [127:0] req_fixed;
    logic [31:0]  req_exp;
    logic [3:0]   grant;
    logic [31:0]  conv_fixed;
    logic [7:0]   conv_exp;
    logic         conv_load;
    logic [31:0]  conv_float;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_float;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    conv_arbiter #(.NUM_REQ(4), .ID_W(2), .CONV_CYCLES(C)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_fixed(req_fixed), .req_exp(req_exp),
        .grant(grant), .conv_fixed(conv_fixed), .conv_exp(conv_exp), .conv_load(conv_load),
        .conv_float(conv_float), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_float(rsp_float), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // value = fixed * 2^exp, truncated to single precision
    function automatic logic [31:0] to_float(input logic [31:0] f, input logic [7:0] e);
        logic        s;
        logic [31:0] m;
        logic [31:0] sh;
        logic [7:0]  be;
        int          p;
        s = f[31];
        m = s ? (~f + 32'd1) : f;
        if (m == 32'd0) return 32'd0;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        be = 8'(127 + p + int'($signed(e)));
        sh = m << (31 - p);
        return {s, be, sh[30:8]};
    endfunction

    // Converter model: garbage until CONV_CYCLES edges after load_new have elapsed.
    int          mcnt;
    logic [31:0] mres;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_float <= GARB;
            mcnt       <= 0;
            mres       <= 32'd0;
        end else if (conv_load) begin
            mres       <= to_float(conv_fixed, conv_exp);
            mcnt       <= C - 1;
            conv_float <= (C == 1) ? to_float(conv_fixed, conv_exp) : GARB;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) conv_float <= mres;
        end
    end

    typedef struct {
        bit           rst_before;
        logic [3:0]   req;
        logic [127:0] fixed;
        logic [31:0]  exp;
        bit           zero;
        logic [3:0]   grant;
        int           id;
        logic [31:0]  flt;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs_zero",
              longint'(|{grant, conv_load, rsp_valid, busy, conv_fixed, conv_exp, rsp_id, rsp_float}), 0);
        rst_n = 1'b1;
    endtask

    // Caller is at a negedge with the DUT idle; returns at the negedge after the response handshake.
    task automatic run_vec(input vec_t v);
        int          lat, load_cnt, load_at, valid_at, bad;
        bit          want_load;
        logic [31:0] sfix, fix_at_load;
        logic [7:0]  sexp, exp_at_load;
        if (v.rst_before) do_reset();
        want_load = 1'b1;
        lat       = C + 2;
`ifdef CONV_ZERO_BYPASS_EN
        if (v.zero) begin
            want_load = 1'b0;
            lat       = 1;
        end
`endif
        sfix = v.fixed[32*v.id +: 32];
        sexp = v.exp[8*v.id +: 8];
        req = v.req; req_fixed = v.fixed; req_exp = v.exp;
        #1;
        check("grant", grant, v.grant);
        check("idle_busy", busy, 0);
        load_cnt = 0; load_at = -1; valid_at = -1; bad = 0;
        fix_at_load = '0; exp_at_load = '0;
        for (int k = 1; k <= C + 8 && valid_at < 0; k++) begin
            @(negedge clk);
            if (conv_load) begin
                load_cnt++;
                if (load_at < 0) begin
                    load_at = k; fix_at_load = conv_fixed; exp_at_load = conv_exp;
                end
            end
            if (grant != 4'd0 || !busy) bad++;
            if (rsp_valid) valid_at = k;
            if (k == 3) begin
                req_fixed = ~v.fixed; req_exp = ~v.exp;
            end
        end
        check("load_count", load_cnt, want_load ? 1 : 0);
        check("load_cycle", load_at, want_load ? 1 : -1);
        if (want_load) begin
            check("conv_operands", {fix_at_load, exp_at_load}, {sfix, sexp});
            check("conv_operands_held", {conv_fixed, conv_exp}, {sfix, sexp});
        end
        check("valid_latency", valid_at, lat);
        check("rsp_id", rsp_id, v.id);
        check("rsp_float", rsp_float, v.flt);
        check("quiet_while_busy", bad, 0);
        @(negedge clk);
        check("rsp_drop", {rsp_valid, busy}, 0);
    endtask

    localparam logic [127:0] F2 = {32'h1, 32'hFFFFFFFF, 32'hD, 32'h1};
    localparam logic [31:0]  E2 = {8'h00, 8'h00, 8'hFF, 8'h01};
    localparam logic [127:0] F3 = {32'h0, 32'h1, 32'h0, 32'h1};
    localparam logic [31:0]  E3 = {8'h00, 8'h01, 8'h00, 8'h00};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          valid_at, bad, xfers;
        vec_t        mw;
        vecs[0]  = '{1'b1, 4'b0001, {96'h0, 32'h1}, 32'h0, 1'b0, 4'b0001, 0, 32'h3F800000};
        vecs[1]  = '{1'b1, 4'b1111, F2, E2, 1'b0, 4'b0001, 0, 32'h40000000};
        vecs[2]  = '{1'b0, 4'b1110, F2, E2, 1'b0, 4'b0010, 1, 32'h40D00000};
        vecs[3]  = '{1'b0, 4'b1100, F2, E2, 1'b0, 4'b0100, 2, 32'hBF800000};
        vecs[4]  = '{1'b0, 4'b1000, F2, E2, 1'b0, 4'b1000, 3, 32'h3F800000};
        vecs[5]  = '{1'b0, 4'b0101, F3, E3, 1'b0, 4'b0001, 0, 32'h3F800000};
        vecs[6]  = '{1'b0, 4'b0101, F3, E3, 1'b0, 4'b0100, 2, 32'h40000000};
        vecs[7]  = '{1'b0, 4'b0101, F3, E3, 1'b0, 4'b0001, 0, 32'h3F800000};
        vecs[8]  = '{1'b0, 4'b0101, F3, E3, 1'b0, 4'b0100, 2, 32'h40000000};
        vecs[9]  = '{1'b0, 4'b0101, F3, E3, 1'b0, 4'b0001, 0, 32'h3F800000};
        vecs[10] = '{1'b0, 4'b0101, F3, E3, 1'b0, 4'b0100, 2, 32'h40000000};
        vecs[11] = '{1'b1, 4'b0001, {32'h5, 96'h0}, 32'h0, 1'b1, 4'b0001, 0, 32'h00000000};
        mw       = '{1'b0, 4'b1010, {32'h1, 32'h0, 32'hD, 32'h0}, {8'h00, 8'h00, 8'hFF, 8'h00},
                     1'b0, 4'b0010, 1, 32'h40D00000};

        rst_n = 1'b0; rsp_ready = 1'b1; req = '0; req_fixed = '0; req_exp = '0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Backpressure: response must hold for 10 cycles, then transfer exactly once.
        do_reset();
        rsp_ready = 1'b0;
        req = 4'b0001; req_fixed = {96'h0, 32'h1}; req_exp = '0;
        valid_at = -1;
        for (int k = 1; k <= C + 8 && valid_at < 0; k++) begin
            @(negedge clk);
            if (k == 2) req = 4'b1111;
            if (rsp_valid) valid_at = k;
        end
        check("bp_latency", valid_at, C + 2);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_float !== 32'h3F800000 || rsp_id !== 2'd0 ||
                grant != 4'd0 || conv_load || !busy) bad++;
        end
        check("bp_hold", bad, 0);
        req = '0; rsp_ready = 1'b1; xfers = 0;
        repeat (4) begin
            if (rsp_valid && rsp_ready) xfers++;
            @(negedge clk);
        end
        check("bp_xfers", xfers, 1);
        check("bp_idle", {rsp_valid, busy}, 0);

        // Reset in the middle of WAIT abandons the conversion and restarts rr_ptr at 0.
        req = 4'b0001; req_fixed = {96'h0, 32'h1}; req_exp = '0;
        #1;
        check("mw_grant", grant, 4'b0001);
        @(negedge clk);
        req = '0;
        repeat (8) @(negedge clk);
        check("mw_busy_before_reset", {busy, conv_fixed}, {1'b1, 32'h1});
        #2 rst_n = 1'b0;
        #1;
        check("mw_async_zero",
              longint'(|{grant, conv_load, rsp_valid, busy, conv_fixed, conv_exp, rsp_id, rsp_float}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_vec(mw);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
